fetch_stage: RTL and testbench

- Instruction-fetch stage of the pipelined ARM-subset core, directly upstream of the combinational instruction memory and feeding the decode stage.
- Owns the program counter, drives the word address into instruction memory, and captures the returned word into the IF/ID pipeline register.
- Handles hazard-unit freeze, EX-stage branch redirect with flush, and self-loop halt detection (B #-1 idiom used to terminate programs).
- Addresses are word indices: sequential next PC = PC+1; branch target = branch PC + 1 + sign-extended imm24, computed in EX.

---
 rtl/core_pkg.sv | 9 +
 rtl/if_id_register.sv | 34 +++
 rtl/fetch_stage.sv | 73 +++++++
 tb/tb_fetch_stage.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// core_pkg: shared widths, reset PC, bubble word and fetch FSM states for the core
package core_pkg;
  localparam int ADDR_WIDTH = 32;
  localparam int INSTR_WIDTH = 32;
  localparam int COUNT_WIDTH = 16;
  localparam logic [ADDR_WIDTH-1:0] RESET_PC = '0;
  localparam logic [INSTR_WIDTH-1:0] BUBBLE = '0;
  typedef enum logic [1:0] {BOOT, RUN, HALT} fetch_state_t;
endpackage

// File: rtl/if_id_register.sv
// if_id_register: IF/ID pipeline register with load, flush and hold
// Ports: clock, reset_n (async active-low); load captures pc_in/instr_in and sets valid;
// flush clears valid and writes a bubble (pc held); neither asserted holds everything.
module if_id_register
  import core_pkg::*;
#(
  parameter int AW = core_pkg::ADDR_WIDTH,
  parameter int IW = core_pkg::INSTR_WIDTH
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          load,
  input  logic          flush,
  input  logic [AW-1:0] pc_in,
  input  logic [IW-1:0] instr_in,
  output logic [AW-1:0] pc,
  output logic [IW-1:0] instruction,
  output logic          valid
);
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pc <= '0;
      instruction <= '0;
      valid <= 1'b0;
    end else if (flush) begin
      instruction <= IW'(BUBBLE);
      valid <= 1'b0;
    end else if (load) begin
      pc <= pc_in;
      instruction <= instr_in;
      valid <= 1'b1;
    end
  end
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch with PC, freeze, branch redirect/flush and self-loop halt
// Ports: clock, reset_n (async active-low); freeze holds PC and IF/ID; branch_taken/branch_address
// redirect and flush; imem_instruction is the word at imem_address (registered PC);
// if_id_* is the IF/ID register; halted flags a detected B #-1; fetch_count/flush_count saturate.
module fetch_stage #(
  parameter int ADDR_WIDTH = core_pkg::ADDR_WIDTH,
  parameter int INSTR_WIDTH = core_pkg::INSTR_WIDTH,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = ADDR_WIDTH'(core_pkg::RESET_PC),
  parameter int COUNT_WIDTH = core_pkg::COUNT_WIDTH
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   freeze,
  input  logic                   branch_taken,
  input  logic [ADDR_WIDTH-1:0]  branch_address,
  input  logic [INSTR_WIDTH-1:0] imem_instruction,
  output logic [ADDR_WIDTH-1:0]  imem_address,
  output logic [ADDR_WIDTH-1:0]  if_id_pc,
  output logic [INSTR_WIDTH-1:0] if_id_instruction,
  output logic                   if_id_valid,
  output logic                   halted,
  output logic [COUNT_WIDTH-1:0] fetch_count,
  output logic [COUNT_WIDTH-1:0] flush_count
);
  import core_pkg::*;
  fetch_state_t state;
  logic redirect, advance, self_loop, last_self;
  logic [ADDR_WIDTH-1:0] last_target;
  always_comb begin
    redirect = state == RUN && branch_taken;
    advance = state == RUN && !branch_taken && !freeze;
    // branch sits in EX while IF/ID holds the slot two words past it
    self_loop = branch_address == if_id_pc - ADDR_WIDTH'(2);
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= BOOT;
      imem_address <= RESET_PC;
      halted <= 1'b0;
      fetch_count <= '0;
      flush_count <= '0;
      last_self <= 1'b0;
      last_target <= '0;
    end else begin
      if (state == BOOT) state <= RUN;
      if (redirect) begin
        imem_address <= branch_address;
        if (~&flush_count) flush_count <= flush_count + 1'b1;
        last_self <= self_loop;
        last_target <= branch_address;
        // two back-to-back self-loop redirects to one address mean B #-1 is spinning
        if (self_loop && last_self && branch_address == last_target) begin
          state <= HALT;
          halted <= 1'b1;
        end
      end else if (advance) begin
        imem_address <= imem_address + 1'b1;
        if (~&fetch_count) fetch_count <= fetch_count + 1'b1;
      end
    end
  end
  if_id_register #(.AW(ADDR_WIDTH), .IW(INSTR_WIDTH)) u_if_id (
    .clock(clock),
    .reset_n(reset_n),
    .load(advance),
    .flush(redirect),
    .pc_in(imem_address + 1'b1),
    .instr_in(imem_instruction),
    .pc(if_id_pc),
    .instruction(if_id_instruction),
    .valid(if_id_valid)
  );
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: scoreboarded directed test of fetch_stage plus a 4-bit-counter instance
module tb_fetch_stage;
  logic clock = 1'b0, reset_n = 1'b0, freeze = 1'b0, branch_taken = 1'b0;
  logic [31:0] branch_address = '0;
  logic [31:0] imem_address, imem_instruction, if_id_pc, if_id_instruction;
  logic if_id_valid, halted;
  logic [15:0] fetch_count, flush_count;
  logic [31:0] imem_address4, imem_instruction4, if_id_pc4, if_id_instruction4;
  logic if_id_valid4, halted4;
  logic [3:0] fetch_count4, flush_count4;
  assign imem_instruction = imem_address;
  assign imem_instruction4 = imem_address4;
  always #5 clock = ~clock;
  fetch_stage dut (
    .clock(clock), .reset_n(reset_n), .freeze(freeze), .branch_taken(branch_taken),
    .branch_address(branch_address), .imem_instruction(imem_instruction),
    .imem_address(imem_address), .if_id_pc(if_id_pc), .if_id_instruction(if_id_instruction),
    .if_id_valid(if_id_valid), .halted(halted), .fetch_count(fetch_count), .flush_count(flush_count)
  );
  fetch_stage #(.COUNT_WIDTH(4)) dut4 (
    .clock(clock), .reset_n(reset_n), .freeze(freeze), .branch_taken(branch_taken),
    .branch_address(branch_address), .imem_instruction(imem_instruction4),
    .imem_address(imem_address4), .if_id_pc(if_id_pc4), .if_id_instruction(if_id_instruction4),
    .if_id_valid(if_id_valid4), .halted(halted4), .fetch_count(fetch_count4), .flush_count(flush_count4)
  );
  typedef struct {
    logic [31:0] pc, ipc, ins;
    logic val, halt;
    logic [15:0] fc, flc;
    logic [3:0] fc4;
  } exp_t;
  exp_t q[$];
  int vectors = 0, miscompares = 0;
  int m_st;
  logic [31:0] m_pc, m_ipc, m_ins, m_ptgt;
  logic m_val, m_halt, m_pself;
  logic [15:0] m_fc, m_flc;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic model_reset();
    m_st = 0; m_pc = 0; m_ipc = 0; m_ins = 0; m_ptgt = 0;
    m_val = 0; m_halt = 0; m_pself = 0; m_fc = 0; m_flc = 0;
    q.delete();
  endtask
  task automatic step();
    exp_t e;
    logic self;
    if (m_st == 0) m_st = 1;
    else if (m_st == 1) begin
      if (branch_taken) begin
        self = branch_address == m_ipc - 32'd2;
        if (self && m_pself && branch_address == m_ptgt) begin
          m_st = 2;
          m_halt = 1;
        end
        m_pself = self; m_ptgt = branch_address;
        m_pc = branch_address; m_val = 0; m_ins = 0;
        if (m_flc != 16'hffff) m_flc++;
      end else if (!freeze) begin
        m_ins = m_pc; m_ipc = m_pc + 1; m_val = 1; m_pc = m_pc + 1;
        if (m_fc != 16'hffff) m_fc++;
      end
    end
    e.pc = m_pc; e.ipc = m_ipc; e.ins = m_ins; e.val = m_val; e.halt = m_halt;
    e.fc = m_fc; e.flc = m_flc; e.fc4 = m_fc > 15 ? 4'd15 : m_fc[3:0];
    q.push_back(e);
    @(posedge clock);
    #1;
    e = q.pop_front();
    chk("sb_pc", imem_address, e.pc);
    chk("sb_valid", 32'(if_id_valid), 32'(e.val));
    if (e.val) chk("sb_ifid_pc", if_id_pc, e.ipc);
    chk("sb_instr", if_id_instruction, e.ins);
    chk("sb_halted", 32'(halted), 32'(e.halt));
    chk("sb_fetch_count", 32'(fetch_count), 32'(e.fc));
    chk("sb_flush_count", 32'(flush_count), 32'(e.flc));
    chk("sb_fetch_count4", 32'(fetch_count4), 32'(e.fc4));
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end
  initial begin
    model_reset();
    #12;
    chk("rst_pc", imem_address, 32'd0);
    chk("rst_valid", 32'(if_id_valid), 32'd0);
    chk("rst_ifid_pc", if_id_pc, 32'd0);
    chk("rst_instr", if_id_instruction, 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_counts", {fetch_count, flush_count}, 32'd0);
    reset_n = 1'b1;
    step();
    chk("boot_pc", imem_address, 32'd0);
    chk("boot_valid", 32'(if_id_valid), 32'd0);
    step();
    chk("first_valid", 32'(if_id_valid), 32'd1);
    chk("first_instr", if_id_instruction, 32'd0);
    chk("first_ifid_pc", if_id_pc, 32'd1);
    step(); step();
    chk("seq_pc3", imem_address, 32'd3);
    chk("seq_fetch3", 32'(fetch_count), 32'd3);
    step(); step();
    freeze = 1'b1;
    repeat (3) step();
    chk("frz_pc", imem_address, 32'd5);
    chk("frz_instr", if_id_instruction, 32'd4);
    chk("frz_ifid_pc", if_id_pc, 32'd5);
    chk("frz_fetch", 32'(fetch_count), 32'd5);
    freeze = 1'b0;
    step();
    chk("unfrz_pc", imem_address, 32'd6);
    repeat (32) step();
    chk("run_pc38", imem_address, 32'd38);
    chk("run_fetch38", 32'(fetch_count), 32'd38);
    chk("sat_fetch4", 32'(fetch_count4), 32'd15);
    branch_taken = 1'b1; branch_address = 32'd28;
    step();
    chk("br_pc", imem_address, 32'd28);
    chk("br_valid", 32'(if_id_valid), 32'd0);
    chk("br_flush", 32'(flush_count), 32'd1);
    branch_taken = 1'b0;
    step();
    chk("br_tgt_instr", if_id_instruction, 32'd28);
    chk("br_tgt_ifid_pc", if_id_pc, 32'd29);
    branch_taken = 1'b1; freeze = 1'b1; branch_address = 32'd10;
    step();
    chk("brfrz_pc", imem_address, 32'd10);
    chk("brfrz_valid", 32'(if_id_valid), 32'd0);
    chk("brfrz_flush", 32'(flush_count), 32'd2);
    chk("brfrz_fetch", 32'(fetch_count), 32'd39);
    branch_taken = 1'b0; freeze = 1'b0;
    repeat (38) step();
    chk("pre_loop_pc", imem_address, 32'd48);
    chk("pre_loop_ifid_pc", if_id_pc, 32'd48);
    branch_taken = 1'b1; branch_address = 32'd46;
    step();
    chk("loop1_halted", 32'(halted), 32'd0);
    branch_taken = 1'b0;
    step(); step();
    branch_taken = 1'b1;
    step();
    chk("halt_flag", 32'(halted), 32'd1);
    chk("halt_pc", imem_address, 32'd46);
    chk("halt_valid", 32'(if_id_valid), 32'd0);
    branch_address = 32'd3;
    step();
    branch_taken = 1'b0;
    repeat (3) step();
    chk("halt_hold_pc", imem_address, 32'd46);
    chk("halt_hold_flag", 32'(halted), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_halted", 32'(halted), 32'd0);
    chk("async_rst_pc", imem_address, 32'd0);
    chk("async_rst_fetch", 32'(fetch_count), 32'd0);
    chk("sb_drained", 32'(q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
